// File: rtl/hdmi_mode_sequencer.sv
// Configures the HDMI timing generator from a built-in mode table: pulses the
// I2C mux reset, then presents one setup request over a four-phase ENA/ACK handshake.
`timescale 1ns/1ps
module hdmi_mode_sequencer #(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned ACK_TIMEOUT  = 1024
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start__ENA,
    input  logic [1:0]  start_mode,
    output logic        start__RDY,
    output logic        done__ENA,
    output logic [1:0]  done_status,
    output logic        busy,
    output logic        mux_reset_n,
    output logic        setup__ENA,
    output logic [15:0] setup_ahEnd,
    output logic [15:0] setup_ahFrontEnd,
    output logic [15:0] setup_avEnd,
    output logic [15:0] setup_avFrontEnd,
    output logic [7:0]  setup_ahBackSync,
    output logic [7:0]  setup_ahSyncWidth,
    output logic [7:0]  setup_avBackSync,
    output logic [7:0]  setup_avSyncWidth,
    input  logic        setup__ACK
);

    localparam int unsigned CNT_MAX  = (RESET_CYCLES > ACK_TIMEOUT) ? RESET_CYCLES : ACK_TIMEOUT;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX);
    localparam int unsigned FIELDS_W = 96;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

    localparam logic [1:0] ST_OK    = 2'd0;
    localparam logic [1:0] ST_BAD   = 2'd1;
    localparam logic [1:0] ST_TMO   = 2'd2;
    localparam logic [1:0] MODE_BAD = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUXRST,
        S_SETUP,
        S_WAITCLR,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic [1:0]          status_d;
    logic                mux_d;
    logic [FIELDS_W-1:0] fields_q, fields_d;

    assign start__RDY = (state_q == S_IDLE) && !setup__ACK;
    assign busy       = (state_q != S_IDLE);

    // Next-state, counter and status selection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        status_d = ST_OK;
        mux_d    = mux_reset_n;
        case (state_q)
            S_IDLE: begin
                if (start__ENA && start__RDY) begin
                    mode_d = start_mode;
                    cnt_d  = '0;
                    if (start_mode == MODE_BAD) begin
                        state_d  = S_DONE;
                        status_d = ST_BAD;
                    end else begin
                        state_d = S_MUXRST;
                        mux_d   = 1'b0;
                    end
                end
            end
            S_MUXRST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    mux_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SETUP: begin
                // An ACK arriving on the terminal count takes priority over the timeout
                if (setup__ACK) begin
                    state_d = S_WAITCLR;
                    cnt_d   = '0;
                end else if (cnt_q == ACK_LAST) begin
                    state_d  = S_DONE;
                    status_d = ST_TMO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAITCLR: begin
                if (!setup__ACK) begin
                    state_d  = S_DONE;
                    status_d = ST_OK;
                end else if (cnt_q == ACK_LAST) begin
                    state_d  = S_DONE;
                    status_d = ST_TMO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Timing fields are driven only while the setup request is up
    always_comb begin
        fields_d = '0;
        if (state_d == S_SETUP) begin
            case (mode_q)
                2'd0:    fields_d = {16'd800,  16'd656,  16'd525,  16'd490,  8'd48,  8'd96, 8'd33, 8'd2};
                2'd1:    fields_d = {16'd1650, 16'd1390, 16'd750,  16'd725,  8'd220, 8'd40, 8'd20, 8'd5};
                2'd2:    fields_d = {16'd2200, 16'd2008, 16'd1125, 16'd1084, 8'd148, 8'd44, 8'd36, 8'd5};
                default: fields_d = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mode_q      <= '0;
            mux_reset_n <= 1'b0;
            setup__ENA  <= 1'b0;
            done__ENA   <= 1'b0;
            done_status <= ST_OK;
            fields_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            mux_reset_n <= mux_d;
            setup__ENA  <= (state_d == S_SETUP);
            done__ENA   <= (state_d == S_DONE);
            done_status <= status_d;
            fields_q    <= fields_d;
        end
    end

    assign setup_ahEnd       = fields_q[95:80];
    assign setup_ahFrontEnd  = fields_q[79:64];
    assign setup_avEnd       = fields_q[63:48];
    assign setup_avFrontEnd  = fields_q[47:32];
    assign setup_ahBackSync  = fields_q[31:24];
    assign setup_ahSyncWidth = fields_q[23:16];
    assign setup_avBackSync  = fields_q[15:8];
    assign setup_avSyncWidth = fields_q[7:0];

endmodule

// File: tb/tb_hdmi_mode_sequencer.sv
// Scoreboard bench for hdmi_mode_sequencer: transactions are modelled as cycle
// windows derived from the mode/handshake rules; done responses are queued and popped by a monitor.
`timescale 1ns/1ps
module tb_hdmi_mode_sequencer;

    localparam int R  = 16;
    localparam int TO = 32;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        start__ENA = 1'b0;
    logic [1:0]  start_mode = 2'd0;
    logic        start__RDY;
    logic        done__ENA;
    logic [1:0]  done_status;
    logic        busy;
    logic        mux_reset_n;
    logic        setup__ENA;
    logic        setup__ACK = 1'b0;
    logic [15:0] s_ahEnd, s_ahFrontEnd, s_avEnd, s_avFrontEnd;
    logic [7:0]  s_ahBackSync, s_ahSyncWidth, s_avBackSync, s_avSyncWidth;

    hdmi_mode_sequencer #(.RESET_CYCLES(R), .ACK_TIMEOUT(TO)) dut (
        .CLK               (CLK),
        .nRST              (nRST),
        .start__ENA        (start__ENA),
        .start_mode        (start_mode),
        .start__RDY        (start__RDY),
        .done__ENA         (done__ENA),
        .done_status       (done_status),
        .busy              (busy),
        .mux_reset_n       (mux_reset_n),
        .setup__ENA        (setup__ENA),
        .setup_ahEnd       (s_ahEnd),
        .setup_ahFrontEnd  (s_ahFrontEnd),
        .setup_avEnd       (s_avEnd),
        .setup_avFrontEnd  (s_avFrontEnd),
        .setup_ahBackSync  (s_ahBackSync),
        .setup_ahSyncWidth (s_ahSyncWidth),
        .setup_avBackSync  (s_avBackSync),
        .setup_avSyncWidth (s_avSyncWidth),
        .setup__ACK        (setup__ACK)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // One configuration request: start cycle, mode, ACK rise offset into setup, ACK hold into clear phase
    typedef struct { int T; int mode; int d1; int d2; } txn_t;
    typedef struct { int cyc; int status; } exp_t;

    exp_t sb[$];
    txn_t cur;
    bit   have_txn = 1'b0;
    bit   mux_prev = 1'b0;
    bit   chk_en   = 1'b0;
    int   n_chk    = 0;
    int   n_fail   = 0;

    function automatic int f_S(input txn_t t);  return t.T + R + 1;           endfunction
    function automatic int f_W(input txn_t t);  return f_S(t) + t.d1 + 1;     endfunction
    function automatic bit f_ok1(input txn_t t); return t.d1 <= TO - 1;       endfunction

    function automatic int f_done(input txn_t t);
        if (t.mode == 3)     return t.T + 1;
        if (!f_ok1(t))       return f_S(t) + TO;
        if (t.d2 <= TO - 1)  return f_W(t) + t.d2 + 1;
        return f_W(t) + TO;
    endfunction

    function automatic int f_status(input txn_t t);
        if (t.mode == 3)                  return 1;
        if (!f_ok1(t) || t.d2 > TO - 1)   return 2;
        return 0;
    endfunction

    function automatic int f_setup_end(input txn_t t);
        return f_ok1(t) ? f_S(t) + t.d1 : f_S(t) + TO - 1;
    endfunction

    function automatic bit f_ack(input txn_t t, input int c);
        return (t.mode != 3) && (c >= f_S(t) + t.d1) && (c < f_W(t) + t.d2);
    endfunction

    function automatic int f_end(input txn_t t);
        int a;
        if (t.mode == 3) return t.T + 1;
        a = f_W(t) + t.d2;
        return (f_done(t) > a) ? f_done(t) : a;
    endfunction

    // Packed in the order {ahEnd, ahFrontEnd, avEnd, avFrontEnd, ahBackSync, ahSyncWidth, avBackSync, avSyncWidth}
    function automatic logic [95:0] f_fields(input int mode);
        int v[8];
        case (mode)
            0: v = '{800, 656, 48, 96, 525, 490, 33, 2};
            1: v = '{1650, 1390, 220, 40, 750, 725, 20, 5};
            2: v = '{2200, 2008, 148, 44, 1125, 1084, 36, 5};
            default: v = '{0, 0, 0, 0, 0, 0, 0, 0};
        endcase
        return {16'(v[0]), 16'(v[1]), 16'(v[4]), 16'(v[5]), 8'(v[2]), 8'(v[3]), 8'(v[6]), 8'(v[7])};
    endfunction

    function automatic bit exp_busy(input int c);
        return have_txn && (c >= cur.T + 1) && (c <= f_done(cur));
    endfunction

    function automatic bit exp_setup(input int c);
        return have_txn && (cur.mode != 3) && (c >= f_S(cur)) && (c <= f_setup_end(cur));
    endfunction

    function automatic bit exp_mux(input int c);
        if (!have_txn || cur.mode == 3 || c <= cur.T) return mux_prev;
        return (c >= f_S(cur));
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [95:0] dut_fields();
        return {s_ahEnd, s_ahFrontEnd, s_avEnd, s_avFrontEnd,
                s_ahBackSync, s_ahSyncWidth, s_avBackSync, s_avSyncWidth};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mux"},    96'(mux_reset_n), 96'(0));
        check({tag, "_setup"},  96'(setup__ENA),  96'(0));
        check({tag, "_done"},   96'(done__ENA),   96'(0));
        check({tag, "_status"}, 96'(done_status), 96'(0));
        check({tag, "_busy"},   96'(busy),        96'(0));
        check({tag, "_fields"}, dut_fields(),     96'(0));
    endtask

    // Monitor: per-cycle waveform expectations plus done-queue scoreboard
    always @(negedge CLK) begin
        int   c;
        exp_t e;
        if (nRST && chk_en) begin
            c = cyc;
            check("busy",        96'(busy),        96'(exp_busy(c)));
            check("start_rdy",   96'(start__RDY),  96'(!exp_busy(c) && !setup__ACK));
            check("setup_ena",   96'(setup__ENA),  96'(exp_setup(c)));
            check("mux_reset_n", 96'(mux_reset_n), 96'(exp_mux(c)));
            check("fields",      dut_fields(),     exp_setup(c) ? f_fields(cur.mode) : 96'(0));
            if (sb.size() > 0 && sb[0].cyc < c) begin
                n_chk++;
                n_fail++;
                $display("FAIL done_missing cyc=%0d actual=none expected_at=%0d", c, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (done__ENA) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL done_unexpected cyc=%0d actual_status=%0d expected=no_done", c, done_status);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle",  96'(c),           96'(e.cyc));
                    check("done_status", 96'(done_status), 96'(e.status));
                end
            end else begin
                check("status_idle", 96'(done_status), 96'(0));
            end
        end
    end

    task automatic issue(input int mode, input int d1, input int d2, output txn_t t);
        t.T = cyc; t.mode = mode; t.d1 = d1; t.d2 = d2;
        start__ENA = 1'b1;
        start_mode = 2'(mode);
        if (have_txn && cur.mode != 3) mux_prev = 1'b1;
        cur = t;
        have_txn = 1'b1;
        sb.push_back('{cyc: f_done(t), status: f_status(t)});
    endtask

    task automatic run_txn(input int mode, input int d1, input int d2, input bit spur);
        txn_t t;
        issue(mode, d1, d2, t);
        for (int k = 0; k < f_end(t) + 1 - t.T; k++) begin
            @(posedge CLK); #1;
            setup__ACK = f_ack(t, cyc);
            start__ENA = 1'b0;
            if (spur && (exp_busy(cyc) || setup__ACK) && ($urandom_range(0, 3) == 0)) begin
                start__ENA = 1'b1;
                start_mode = 2'($urandom_range(0, 3));
            end
        end
    endtask

    task automatic reset_mid_setup();
        txn_t t;
        issue(0, TO + 10, 0, t);
        while (cyc < f_S(t) + 3) begin
            @(posedge CLK); #1;
            start__ENA = 1'b0;
        end
        #2;
        check("pre_rst_setup", 96'(setup__ENA), 96'(1));
        chk_en = 1'b0;
        nRST = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        have_txn = 1'b0;
        mux_prev = 1'b0;
        setup__ACK = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        nRST = 1'b1;
        chk_en = 1'b1;
        @(posedge CLK); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check_reset_outputs("rst");
        repeat (3) @(posedge CLK);
        #1;
        nRST = 1'b1;
        chk_en = 1'b1;
        while (cyc < 10) begin @(posedge CLK); #1; end

        run_txn(1, 3, 4, 1'b1);           // nominal, start at cycle 10
        run_txn(3, 0, 0, 1'b1);           // invalid mode
        run_txn(0, TO + 3, 5, 1'b0);      // setup timeout, late ACK pulse
        run_txn(0, TO - 1, 2, 1'b1);      // ACK on terminal count
        run_txn(1, TO, 2, 1'b0);          // ACK one cycle too late
        run_txn(2, 0, TO - 1, 1'b1);      // clear on last allowed cycle
        run_txn(2, 1, TO, 1'b0);          // clear-phase timeout, stale ACK
        reset_mid_setup();
        run_txn(2, 5, 3, 1'b0);

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; start__ENA = 1'b0; end
            run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, TO + 4)),
                    int'($urandom_range(0, TO + 4)), 1'b1);
        end

        repeat (5) begin @(posedge CLK); #1; end
        check("queue_empty", 96'(sb.size()), 96'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
